// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mips_muldiv_unit : iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers
// Rev 1.0
// -----------------------------------------------------------------------------
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // acc_q holds {partial/remainder, multiplier/quotient}; multiply shifts it
  // right, divide shifts it left.
  always_comb begin
    is_signed = ~op[0];
    rs_neg    = is_signed & rs_val[WIDTH-1];
    rt_neg    = is_signed & rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          busy_d    = 1'b1;
          is_div_d  = op[1];
          neg_d     = rs_neg ^ rt_neg;
          rem_neg_d = rs_neg;
          div0_d    = op[1] & (rt_val == '0);
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
          opnd_d    = op[1] ? rt_mag : rs_mag;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          acc_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          // With a zero divisor the remainder is |rs|, so restoring the dividend sign returns rs_val.
          lo_d = div0_q ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mips_muldiv_unit : directed self-checking bench for mips_muldiv_unit
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_mips_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one issue cycle; returns just after edge E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic with_mtlo);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    mtlo   = with_mtlo;
    wdata  = 32'hDEAD_BEEF;
    tick();
    start  = 1'b0;
    mtlo   = 1'b0;
    op     = 2'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Follows the operation to its done pulse; poke >= 0 injects start+mthi mid-run.
  task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el,
                           input int poke);
    int          k;
    int          nbusy;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    k       = 0;
    nbusy   = 0;
    hold_hi = hi;
    hold_lo = lo;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) nbusy++;
      if (k == poke) begin
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd9;
        rt_val = 32'd3;
        mthi   = 1'b1;
        wdata  = 32'h0000_1234;
      end
      tick();
      k++;
      if (k == poke + 1) begin
        start = 1'b0;
        mthi  = 1'b0;
        check({tag, " hi held while busy"}, hi, hold_hi);
        check({tag, " lo held while busy"}, lo, hold_lo);
      end
    end
    check({tag, " busy cycles"}, 32'(nbusy), 32'd33);
    check({tag, " done edge"}, 32'(k), 32'd33);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    tick();
    check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    check({tag, " idle after done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nd;
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = '0;
    rt_val = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    wdata  = '0;
    tick();
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu max busy after E0", {31'd0, busy}, 32'd1);
    wait_done("multu max", 32'hFFFF_FFFE, 32'h0000_0001, -1);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_done("mult -3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);

    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done("mult min*min", 32'h4000_0000, 32'h0000_0000, -1);

    issue(2'b11, 32'd100, 32'd7, 1'b0);
    wait_done("divu 100/7", 32'd2, 32'd14, -1);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);

    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_done("div 7/-2", 32'd1, 32'hFFFF_FFFD, -1);

    issue(2'b11, 32'd5, 32'd0, 1'b0);
    wait_done("divu 5/0", 32'd5, 32'hFFFF_FFFF, -1);

    issue(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
    wait_done("div -5/0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div wrap", 32'd0, 32'h8000_0000, -1);

    issue(2'b11, 32'd100, 32'd7, 1'b0);
    wait_done("divu poked", 32'd2, 32'd14, 5);

    mthi  = 1'b1;
    wdata = 32'h0000_1234;
    tick();
    mthi  = 1'b0;
    check("mthi hi", hi, 32'h0000_1234);
    check("mthi lo unchanged", lo, 32'd14);

    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h0000_A5A5;
    tick();
    mthi  = 1'b0;
    mtlo  = 1'b0;
    check("mthi+mtlo hi", hi, 32'h0000_A5A5);
    check("mthi+mtlo lo", lo, 32'h0000_A5A5);

    issue(2'b01, 32'd3, 32'd5, 1'b1);
    check("start beats mtlo", lo, 32'h0000_A5A5);
    check("start beats mtlo busy", {31'd0, busy}, 32'd1);
    wait_done("multu 3x5 a", 32'd0, 32'd15, -1);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun reset busy", {31'd0, busy}, 32'd0);
    check("midrun reset done", {31'd0, done}, 32'd0);
    check("midrun reset hi", hi, 32'd0);
    check("midrun reset lo", lo, 32'd0);
    nd = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) nd++;
    end
    check("no done after reset", 32'(nd), 32'd0);

    issue(2'b01, 32'd3, 32'd5, 1'b0);
    wait_done("multu 3x5 b", 32'd0, 32'd15, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV and DIVU one bit per cycle. It holds `busy` high so the pipeline stalls dependent MFHI/MFLO and further mul/div issue, and it services MTHI/MTLO. It sits beside the ALU in the execute stage and is started by the decode controller.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  issue a mul/div; sampled only when idle
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `rs_val`  in  WIDTH  multiplicand / dividend
- `rt_val`  in  WIDTH  multiplier / divisor
- `mthi`  in  1  write `wdata` to HI (idle only)
- `mtlo`  in  1  write `wdata` to LO (idle only)
- `wdata`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  operation in progress; pipeline stall request
- `done`  out  1  one-cycle pulse; HI/LO hold a new result
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States:
  - IDLE → RUN on `start`. Operands, `op` and sign flags are latched. The iteration counter is cleared.
  - RUN stays for exactly `WIDTH` cycles, with one shift-add (multiply) or one restoring subtract-shift (divide) per cycle, then moves to FIX.
  - FIX applies sign correction, writes HI/LO, pulses `done` and returns to IDLE.
- Signed ops (MULT, DIV) operate on magnitudes (two's-complement absolute values). The sign is restored in FIX.
- Multiply:
  - Produces a 2·`WIDTH`-bit product: HI = upper half, LO = lower half.
  - For MULT, the product is negated when the operand signs differ.
- Divide:
  - LO = quotient, HI = remainder.
  - For DIV, the quotient is negative iff the operand signs differ, and the remainder takes the sign of the dividend (truncating division).
- Divide by zero (DIV or DIVU): LO = all ones, HI = `rs_val`. No sign fix is applied.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is a wrap, not an error.
- Priority in IDLE: `start` > `mthi`/`mtlo`. `mthi` and `mtlo` may both be asserted in the same cycle; both registers then load `wdata`.
- While busy, `start`, `mthi` and `mtlo` are ignored, and HI/LO hold their prior values until FIX.
- `op` is decoded only at start. Later changes to `op` or the operand inputs have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. Internal operand registers are cleared.
- Reset takes effect at any point, including mid-RUN or in FIX. The operation is abandoned, no `done` is produced and HI/LO become 0.
- Edge numbering: `start` is sampled at edge E0.
  - `busy` is high for the `WIDTH`+1 cycles following E0 through E`WIDTH` (RUN plus FIX).
  - At edge E`WIDTH`+1, HI/LO update, `busy` falls and `done` goes high for exactly one cycle.
- New HI/LO values are visible in the same cycle `done` is high.
- A new `start` may be sampled at the edge ending the `done` cycle (back-to-back). Issue-to-issue spacing is `WIDTH`+2 cycles.
- MTHI/MTLO in IDLE updates the register at that edge. The new value is visible the next cycle with zero-cycle latency.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` 33 cycles, then `done` 1 cycle at E33 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIVU 100 / 7 → lo=14, hi=2. DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE (−2) → lo=0xFFFFFFFD, hi=1.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- While busy, pulse `start` (DIVU 9/3) and `mthi` with wdata=0x1234: both ignored, and the original result lands at E33. In IDLE, `mthi`=1 with wdata=0x1234 → hi=0x1234, lo unchanged. `start`+`mtlo` in the same cycle → mul/div starts and lo is not written by MTLO.
- Reset asserted at RUN iteration 10 → next cycle `busy`=0, `done`=0, hi=lo=0, and no `done` pulse follows. A subsequent MULTU 3×5 → lo=15, hi=0 with normal 33-cycle busy.
